// File: rtl/pix_uart_framer.sv
// Pixel FIFO plus frame wrapper (header, count, pixels, checksum, trailer)
// feeding a byte-wide UART transmitter paced by its busy flag.
module pix_uart_framer #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] FRAME_PIX  = 16'd4096,
  parameter logic [7:0]  HDR0       = 8'hA5,
  parameter logic [7:0]  HDR1       = 8'h5A,
  parameter logic [7:0]  TRL        = 8'h0D
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pix_valid,
  input  logic [7:0]                  pix_data,
  input  logic                        uart_tx_busy,
  output logic                        uart_en,
  output logic [7:0]                  uart_din,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        frame_sent
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE, LOAD, WAIT_HI, WAIT_LO
  } state_t;

  typedef enum logic [2:0] {
    B_HDR0, B_HDR1, B_CNTH, B_CNTL,
    B_PIX, B_CSUM, B_TRL
  } sel_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  state_t        state;
  sel_t          sel;
  sel_t          sel_nxt;
  logic [15:0]   pix_cnt;
  logic [7:0]    csum;
  logic          last;
  logic [7:0]    byte_nxt;

  assign full  = fifo_level == LW'(FIFO_DEPTH);
  assign empty = fifo_level == '0;
  assign pop   = (state == LOAD) &&
                 (sel == B_PIX) && !empty;
  // a pop on the same edge frees the slot a full FIFO needs
  assign push  = pix_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= pix_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (pix_valid && !push) overflow <= 1'b1;
    end
  end

  always_comb begin
    byte_nxt = 8'h00;
    unique case (sel)
      B_HDR0:  byte_nxt = HDR0;
      B_HDR1:  byte_nxt = HDR1;
      B_CNTH:  byte_nxt = FRAME_PIX[15:8];
      B_CNTL:  byte_nxt = FRAME_PIX[7:0];
      B_PIX:   byte_nxt = mem[rptr];
      B_CSUM:  byte_nxt = csum;
      B_TRL:   byte_nxt = TRL;
      default: byte_nxt = 8'h00;
    endcase
  end

  always_comb begin
    sel_nxt = B_HDR0;
    unique case (sel)
      B_HDR0:  sel_nxt = B_HDR1;
      B_HDR1:  sel_nxt = B_CNTH;
      B_CNTH:  sel_nxt = B_CNTL;
      B_CNTL:  sel_nxt = B_PIX;
      B_PIX:   sel_nxt = last ? B_CSUM : B_PIX;
      B_CSUM:  sel_nxt = B_TRL;
      default: sel_nxt = B_HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= B_HDR0;
      pix_cnt    <= '0;
      csum       <= '0;
      last       <= 1'b0;
      uart_en    <= 1'b0;
      uart_din   <= '0;
      frame_sent <= 1'b0;
    end else begin
      uart_en    <= 1'b0;
      frame_sent <= 1'b0;
      unique case (state)
        IDLE: begin
          // header waits for a buffered pixel
          if (!empty) begin
            sel   <= B_HDR0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (sel != B_PIX || pop) begin
            uart_en  <= 1'b1;
            uart_din <= byte_nxt;
            state    <= WAIT_HI;
            if (pop) begin
              csum    <= csum + byte_nxt;
              pix_cnt <= pix_cnt + 16'd1;
              last    <= pix_cnt ==
                         FRAME_PIX - 16'd1;
            end
          end
        end
        WAIT_HI: begin
          if (uart_tx_busy) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!uart_tx_busy) begin
            if (sel == B_TRL) begin
              frame_sent <= 1'b1;
              pix_cnt    <= '0;
              csum       <= '0;
              state      <= IDLE;
            end else begin
              sel   <= sel_nxt;
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pix_uart_framer.sv
// Directed bench for pix_uart_framer with a busy-flag UART model
// and an expected-byte scoreboard.
module tb_pix_uart_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       uart_tx_busy;
  logic       uart_en;
  logic [7:0] uart_din;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       frame_sent;

  pix_uart_framer #(
    .FIFO_DEPTH(4),
    .FRAME_PIX (16'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .uart_tx_busy(uart_tx_busy),
    .uart_en     (uart_en),
    .uart_din    (uart_din),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .frame_sent  (frame_sent)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_en = 0;
  int         n_fs = 0;
  int         n_proto = 0;
  int         pend = 0;
  int         hi = 0;
  logic       force_busy = 1'b0;
  logic       armed = 1'b0;
  logic       seen_hi = 1'b0;
  logic [7:0] exp_q [$];
  int         base_en;
  int         base_fs;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // one clock: sample DUT, score bytes, advance UART model
  task automatic step();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (armed && uart_tx_busy) seen_hi = 1'b1;
    else if (armed && seen_hi) armed = 1'b0;
    if (uart_en) begin
      n_en++;
      if (armed) n_proto++;
      armed   = 1'b1;
      seen_hi = 1'b0;
      pend    = 2;
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", 32'(uart_din), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("byte", 32'(uart_din), 32'(e));
      end
    end
    if (frame_sent) n_fs++;
    if (pend > 0) begin
      pend--;
      if (pend == 0) hi = 20;
    end else if (hi > 0) begin
      hi--;
    end
    uart_tx_busy = (hi > 0) || force_busy;
  endtask

  task automatic push_pix(input logic [7:0] d);
    pix_valid = 1'b1;
    pix_data  = d;
    step();
    pix_valid = 1'b0;
  endtask

  task automatic exp_frame(input logic [7:0] p0,
                           input logic [7:0] p1,
                           input logic [7:0] p2,
                           input logic [7:0] p3);
    logic [7:0] s;
    s = p0 + p1 + p2 + p3;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h04);
    exp_q.push_back(p0);
    exp_q.push_back(p1);
    exp_q.push_back(p2);
    exp_q.push_back(p3);
    exp_q.push_back(s);
    exp_q.push_back(8'h0D);
  endtask

  task automatic wait_fs(input int tgt);
    for (int i = 0; i < 3000 && n_fs < tgt; i++)
      step();
    chk("frame_sent_cnt", 32'(n_fs), 32'(tgt));
  endtask

  task automatic frame_end(input string tag,
                           input int frames);
    wait_fs(base_fs + frames);
    chk({tag, "_en_cnt"}, 32'(n_en - base_en),
        32'(10 * frames));
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 0);
    base_en = n_en;
    base_fs = n_fs;
  endtask

  task automatic push_gated(input logic [7:0] d);
    for (int i = 0; i < 200 && fifo_level == 3'd4; i++)
      step();
    push_pix(d);
  endtask

  initial begin
    rst          = 1'b1;
    pix_valid    = 1'b0;
    pix_data     = 8'h00;
    uart_tx_busy = 1'b0;
    repeat (3) step();
    chk("rst_en", 32'(uart_en), 0);
    chk("rst_din", 32'(uart_din), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_fs", 32'(frame_sent), 0);
    rst = 1'b0;
    step();
    base_en = n_en;
    base_fs = n_fs;

    // back-to-back frame
    exp_frame(8'd10, 8'd20, 8'd30, 8'd40);
    push_pix(8'd10);
    push_pix(8'd20);
    push_pix(8'd30);
    push_pix(8'd40);
    frame_end("basic", 1);

    // checksum wraps modulo 256
    exp_frame(8'hFF, 8'hFF, 8'h02, 8'h01);
    push_pix(8'hFF);
    push_pix(8'hFF);
    push_pix(8'h02);
    push_pix(8'h01);
    frame_end("csum", 1);

    // overflow with busy stuck high
    force_busy = 1'b1;
    step();
    exp_frame(8'd1, 8'd2, 8'd3, 8'd4);
    for (int i = 1; i <= 6; i++) push_pix(8'(i));
    step();
    step();
    chk("ovf_level", 32'(fifo_level), 4);
    chk("ovf_flag", 32'(overflow), 1);
    force_busy = 1'b0;
    frame_end("ovf", 1);
    chk("ovf_drain", 32'(fifo_level), 0);
    chk("ovf_sticky", 32'(overflow), 1);

    // slow source starves the FSM in LOAD
    exp_frame(8'd10, 8'd20, 8'd30, 8'd40);
    push_pix(8'd10);
    repeat (99) step();
    push_pix(8'd20);
    repeat (99) step();
    push_pix(8'd30);
    repeat (99) step();
    chk("slow_level", 32'(fifo_level), 0);
    chk("slow_en", 32'(uart_en), 0);
    push_pix(8'd40);
    frame_end("slow", 1);

    // reset after five bytes of a frame
    exp_frame(8'd10, 8'd20, 8'd30, 8'd40);
    push_pix(8'd10);
    push_pix(8'd20);
    push_pix(8'd30);
    push_pix(8'd40);
    for (int i = 0; i < 1000 && n_en < base_en + 5; i++)
      step();
    chk("mid_bytes", 32'(n_en - base_en), 5);
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("mid_en", 32'(uart_en), 0);
    chk("mid_din", 32'(uart_din), 0);
    chk("mid_level", 32'(fifo_level), 0);
    chk("mid_ovf", 32'(overflow), 0);
    chk("mid_fs", 32'(frame_sent), 0);
    rst = 1'b0;
    for (int i = 0; i < 100 && (hi > 0 || pend > 0); i++)
      step();
    step();
    armed = 1'b0;
    exp_q.delete();
    base_en = n_en;
    base_fs = n_fs;
    exp_frame(8'd10, 8'd20, 8'd30, 8'd40);
    push_pix(8'd10);
    push_pix(8'd20);
    push_pix(8'd30);
    push_pix(8'd40);
    frame_end("after_rst", 1);

    // two frames streamed through the small FIFO
    exp_frame(8'h11, 8'h22, 8'h33, 8'h44);
    exp_frame(8'h55, 8'h66, 8'h77, 8'h88);
    push_gated(8'h11);
    push_gated(8'h22);
    push_gated(8'h33);
    push_gated(8'h44);
    push_gated(8'h55);
    push_gated(8'h66);
    push_gated(8'h77);
    push_gated(8'h88);
    frame_end("b2b", 2);
    chk("b2b_ovf", 32'(overflow), 0);
    chk("b2b_level", 32'(fifo_level), 0);

    chk("proto_violations", 32'(n_proto), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
